// File: rtl/operand_forward_unit_if.sv
// E-stage operand resolution bus: instruction/operand inputs from the core,
// resolved operands and hazard status back from the forwarding unit.
interface operand_forward_unit_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = $clog2(DEPTH+1);

  logic                        hold_all;
  logic                        flush_e;
  logic                        ex_valid;
  logic                        ex_regwrite;
  logic                        ex_is_load;
  logic [ADDR_W-1:0]           ex_rd;
  logic [DATA_W-1:0]           ex_result;
  logic [DATA_W-1:0]           mem_rdata;
  logic [NUM_SRC*ADDR_W-1:0]   rs_addr;
  logic [NUM_SRC*DATA_W-1:0]   rf_data;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall_e;
  logic [CNT_W-1:0]            stall_count;

  modport master (
    output hold_all, flush_e, ex_valid, ex_regwrite, ex_is_load, ex_rd,
           ex_result, mem_rdata, rs_addr, rf_data,
    input  src_data, fwd_sel, stall_e, stall_count
  );

  modport slave (
    input  hold_all, flush_e, ex_valid, ex_regwrite, ex_is_load, ex_rd,
           ex_result, mem_rdata, rs_addr, rf_data,
    output src_data, fwd_sel, stall_e, stall_count
  );
endinterface

// File: rtl/operand_forward_unit.sv
// Operand forwarding + load-use hazard unit: DEPTH-slot writer shadow (slot0=M,
// slot1=W, slot2+=post-W) resolving NUM_SRC E-stage operands, with stall counter.
module ofu_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  logic [ADDR_W-1:0]             rs,
  input  logic [DATA_W-1:0]             rf_data,
  input  logic [DEPTH-1:0]              slot_wr,
  input  logic [DEPTH-1:0]              slot_rdy,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  slot_rd,
  input  logic [DEPTH-1:0][DATA_W-1:0]  slot_data,
  output logic [DATA_W-1:0]             src,
  output logic [SEL_W-1:0]              sel,
  output logic                          stall_req
);
  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    src       = rf_data;
    sel       = '0;
    stall_req = 1'b0;
    if (rs != '0) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (slot_wr[k] && slot_rd[k] == rs) begin
          sel       = SEL_W'(k+1);
          src       = slot_data[k];
          stall_req = ~slot_rdy[k];
        end
      end
    end
  end
endmodule

module operand_forward_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  operand_forward_unit_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [ADDR_W-1:0] rd;
    logic              ready;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t [DEPTH-1:0]  slot_q, slot_d;
  logic  [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DEPTH-1:0]              slot_wr, slot_rdy;
  logic [DEPTH-1:0][ADDR_W-1:0]  slot_rd;
  logic [DEPTH-1:0][DATA_W-1:0]  slot_data;

  logic [NUM_SRC-1:0][ADDR_W-1:0] rs_arr;
  logic [NUM_SRC-1:0][DATA_W-1:0] rf_arr, src_arr;
  logic [NUM_SRC-1:0][SEL_W-1:0]  sel_arr;
  logic [NUM_SRC-1:0]             stall_req;
  logic                           stall_e;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_wr[k]   = slot_q[k].valid & slot_q[k].regwrite;
      slot_rdy[k]  = slot_q[k].ready;
      slot_rd[k]   = slot_q[k].rd;
      slot_data[k] = slot_q[k].data;
    end
  end

  assign rs_arr = bus.rs_addr;
  assign rf_arr = bus.rf_data;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    ofu_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_lane (
      .rs        (rs_arr[i]),
      .rf_data   (rf_arr[i]),
      .slot_wr   (slot_wr),
      .slot_rdy  (slot_rdy),
      .slot_rd   (slot_rd),
      .slot_data (slot_data),
      .src       (src_arr[i]),
      .sel       (sel_arr[i]),
      .stall_req (stall_req[i])
    );
  end

  // Only registered slot state feeds the stall, keeping ex_result/mem_rdata off this path.
  assign stall_e         = bus.ex_valid & ~bus.flush_e & (|stall_req);
  assign bus.stall_e     = stall_e;
  assign bus.src_data    = src_arr;
  assign bus.fwd_sel     = sel_arr;
  assign bus.stall_count = cnt_q;

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (!bus.hold_all) begin
      slot_d[0] = '0;
      if (bus.ex_valid && !bus.flush_e && !stall_e) begin
        slot_d[0].valid    = 1'b1;
        slot_d[0].regwrite = bus.ex_regwrite;
        slot_d[0].rd       = bus.ex_rd;
        slot_d[0].ready    = ~bus.ex_is_load;
        slot_d[0].data     = bus.ex_result;
      end
      // A pending load picks up its memory data on the way from M into W.
      slot_d[1] = slot_q[0];
      if (slot_q[0].valid && !slot_q[0].ready) begin
        slot_d[1].data  = bus.mem_rdata;
        slot_d[1].ready = 1'b1;
      end
      for (int k = 2; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
      if (stall_e && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed bench for operand_forward_unit: forwarding, load-use stall, hold,
// flush, x0 and async reset scenarios with hand-computed expectations.
module tb_operand_forward_unit;
  localparam int DATA_W = 32, ADDR_W = 5, NUM_SRC = 2, DEPTH = 3, CNT_W = 16;
  localparam logic [31:0] RF0 = 32'h0000_1000;
  localparam logic [31:0] RF1 = 32'h0000_2000;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  operand_forward_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
                            .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  operand_forward_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
                         .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ex(input logic v, input logic rw, input logic ld,
                    input logic [4:0] rd, input logic [31:0] res);
    bus.ex_valid = v; bus.ex_regwrite = rw; bus.ex_is_load = ld;
    bus.ex_rd = rd; bus.ex_result = res;
  endtask

  task automatic rs(input logic [4:0] r0, input logic [4:0] r1);
    bus.rs_addr = {r1, r0};
  endtask

  task automatic idle(input int n);
    ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    rs(5'd0, 5'd0);
    repeat (n) tick();
  endtask

  function automatic logic [1:0] sel(input int i);
    logic [3:0] s;
    s = bus.fwd_sel;
    return s[i*2 +: 2];
  endfunction

  function automatic logic [31:0] src(input int i);
    logic [63:0] d;
    d = bus.src_data;
    return d[i*32 +: 32];
  endfunction

  initial begin
    reset_n = 1'b0;
    bus.hold_all = 1'b0; bus.flush_e = 1'b0; bus.mem_rdata = '0;
    bus.rf_data = {RF1, RF0};
    ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    rs(5'd5, 5'd6);

    // reset state
    smp();
    chk("rst_stall", bus.stall_e, 1'b0);
    chk("rst_sel", bus.fwd_sel, 4'd0);
    chk("rst_src", bus.src_data, {RF1, RF0});
    chk("rst_cnt", bus.stall_count, 16'd0);
    #1 reset_n = 1'b1;
    tick();

    // ALU -> ALU back-to-back
    ex(1'b1, 1'b1, 1'b0, 5'd5, 32'h11); rs(5'd0, 5'd0);
    tick();
    ex(1'b1, 1'b1, 1'b0, 5'd9, 32'h22); rs(5'd5, 5'd0);
    smp();
    chk("alu_sel0", sel(0), 2'd1);
    chk("alu_src0", src(0), 32'h11);
    chk("alu_stall", bus.stall_e, 1'b0);
    chk("alu_sel1", sel(1), 2'd0);
    chk("alu_src1", src(1), RF1);
    tick(); idle(3);

    // load-use: one stall, then forward from slot1
    ex(1'b1, 1'b1, 1'b1, 5'd6, 32'h100); rs(5'd0, 5'd0);
    tick();
    ex(1'b1, 1'b1, 1'b0, 5'd8, 32'h55); rs(5'd0, 5'd6);
    bus.mem_rdata = 32'hDEAD;
    smp();
    chk("lu_stall", bus.stall_e, 1'b1);
    chk("lu_sel_m", sel(1), 2'd1);
    tick();
    smp();
    chk("lu_stall_end", bus.stall_e, 1'b0);
    chk("lu_sel_w", sel(1), 2'd2);
    chk("lu_src_w", src(1), 32'hDEAD);
    chk("lu_cnt", bus.stall_count, 16'd1);
    tick(); idle(3);

    // two writers to x7, youngest wins, both operands read x7
    ex(1'b1, 1'b1, 1'b0, 5'd7, 32'd1); rs(5'd0, 5'd0);
    tick();
    ex(1'b1, 1'b1, 1'b0, 5'd7, 32'd2);
    tick();
    ex(1'b1, 1'b0, 1'b0, 5'd0, 32'd0); rs(5'd7, 5'd7);
    smp();
    chk("yw_sel0", sel(0), 2'd1);
    chk("yw_src0", src(0), 32'd2);
    chk("yw_sel1", sel(1), 2'd1);
    chk("yw_src1", src(1), 32'd2);
    tick(); idle(3);

    // load to x0 never forwards or stalls
    ex(1'b1, 1'b1, 1'b1, 5'd0, 32'h44); rs(5'd0, 5'd0);
    tick();
    ex(1'b1, 1'b0, 1'b0, 5'd0, 32'd0); rs(5'd0, 5'd0);
    smp();
    chk("x0_stall", bus.stall_e, 1'b0);
    chk("x0_sel", sel(0), 2'd0);
    chk("x0_src", src(0), RF0);
    tick(); idle(3);

    // load-use under hold_all: stall persists, counter frozen
    ex(1'b1, 1'b1, 1'b1, 5'd6, 32'd0); rs(5'd0, 5'd0);
    tick();
    ex(1'b1, 1'b1, 1'b0, 5'd9, 32'd0); rs(5'd6, 5'd0);
    bus.mem_rdata = 32'hBEEF;
    bus.hold_all = 1'b1;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("hold_stall", bus.stall_e, 1'b1);
      chk("hold_cnt", bus.stall_count, 16'd1);
      tick();
    end
    bus.hold_all = 1'b0;
    smp();
    chk("rel_stall", bus.stall_e, 1'b1);
    tick();
    smp();
    chk("rel_stall_end", bus.stall_e, 1'b0);
    chk("rel_sel", sel(0), 2'd2);
    chk("rel_src", src(0), 32'hBEEF);
    chk("rel_cnt", bus.stall_count, 16'd2);
    tick(); idle(3);

    // flush wins over a pending load-use stall
    ex(1'b1, 1'b1, 1'b1, 5'd6, 32'd0); rs(5'd0, 5'd0);
    tick();
    ex(1'b1, 1'b1, 1'b0, 5'd9, 32'd0); rs(5'd6, 5'd0);
    bus.flush_e = 1'b1;
    smp();
    chk("fl_stall", bus.stall_e, 1'b0);
    chk("fl_sel", sel(0), 2'd1);
    tick();
    bus.flush_e = 1'b0;
    smp();
    chk("fl_cnt", bus.stall_count, 16'd2);
    chk("fl_sel_w", sel(0), 2'd2);
    chk("fl_src_w", src(0), 32'hBEEF);

    // async reset with slots occupied
    ex(1'b1, 1'b1, 1'b0, 5'd10, 32'h77); rs(5'd10, 5'd6);
    tick();
    smp();
    chk("pre_rst_sel", bus.fwd_sel, {2'd3, 2'd1});
    #2 reset_n = 1'b0;
    #1;
    chk("ar_sel", bus.fwd_sel, 4'd0);
    chk("ar_src", bus.src_data, {RF1, RF0});
    chk("ar_stall", bus.stall_e, 1'b0);
    chk("ar_cnt", bus.stall_count, 16'd0);
    ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    smp();
    reset_n = 1'b1;
    tick();
    smp();
    chk("post_rst_sel", bus.fwd_sel, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
